// File: rtl/temporizador_pkg.sv
// rtl/temporizador_pkg.sv - shared BCD constants, digit record and arithmetic helpers for the mm:ss countdown (optional ADD_30S_EN helper)
package temporizador_pkg;

    localparam logic [3:0] BCD_MAX_UNI     = 4'd9;
    localparam logic [3:0] BCD_MAX_SEG_DEZ = 4'd5;
    localparam logic [3:0] TECLA_MAX       = 4'd9;

    typedef struct packed {
        logic [3:0] min_dez;
        logic [3:0] min_uni;
        logic [3:0] seg_dez;
        logic [3:0] seg_uni;
    } tempo_t;

    // Largest value the add path may produce: 99:59
    localparam tempo_t SATURACAO = '{min_dez: 4'd9, min_uni: 4'd9, seg_dez: 4'd5, seg_uni: 4'd9};

    // One-second BCD decrement; caller guarantees the value is not 00:00.
    // A seconds-tens digit above 5 simply decrements, so keyed 00:99 runs 99,98..90,89.
    function automatic tempo_t decrementa(input tempo_t t);
        tempo_t r;
        r = t;
        if (t.seg_uni != 4'd0) begin
            r.seg_uni = t.seg_uni - 4'd1;
        end else begin
            r.seg_uni = BCD_MAX_UNI;
            if (t.seg_dez != 4'd0) begin
                r.seg_dez = t.seg_dez - 4'd1;
            end else begin
                r.seg_dez = BCD_MAX_SEG_DEZ;
                if (t.min_uni != 4'd0) begin
                    r.min_uni = t.min_uni - 4'd1;
                end else begin
                    r.min_uni = BCD_MAX_UNI;
                    r.min_dez = t.min_dez - 4'd1;
                end
            end
        end
        return r;
    endfunction

`ifdef ADD_30S_EN
    // Adds 30 s; seconds are normalised to 0..59 with carry into minutes,
    // and anything past 99 minutes clamps to 99:59.
    function automatic tempo_t soma_30(input tempo_t t);
        tempo_t r;
        int     segs;
        int     mins;
        segs = int'(t.seg_dez) * 10 + int'(t.seg_uni) + 30;
        mins = int'(t.min_dez) * 10 + int'(t.min_uni) + segs / 60;
        segs = segs % 60;
        if (mins > 99) begin
            r = SATURACAO;
        end else begin
            r.min_dez = 4'(mins / 10);
            r.min_uni = 4'(mins % 10);
            r.seg_dez = 4'(segs / 10);
            r.seg_uni = 4'(segs % 10);
        end
        return r;
    endfunction
`endif

endpackage

// File: rtl/temporizador_divisor_tick.sv
// rtl/temporizador_divisor_tick.sv - one-second prescaler producing a single-cycle tick while enabled
module divisor_tick #(
    parameter int TICKS_PER_SEC = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int              W   = $clog2(TICKS_PER_SEC);
    localparam logic [W-1:0]    MAX = W'(TICKS_PER_SEC - 1);

    logic [W-1:0] cnt;

    // Count only while enabled; dropping en discards the partial second
    always_ff @(posedge clk) begin
        if (rst || clear || !en) begin
            cnt <= '0;
        end else if (cnt == MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == MAX);

endmodule

// File: rtl/temporizador.sv
// rtl/temporizador.sv - mm:ss BCD countdown timer feeding the magnetron controller; ADD_30S_EN enables the +30 s strobe
import temporizador_pkg::*;

module temporizador #(
    parameter int TICKS_PER_SEC = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clrn,
    input  logic       tecla_valida,
    input  logic [3:0] tecla,
    input  logic       ligar,
`ifdef ADD_30S_EN
    input  logic       adicionar_30,
`endif
    output logic [3:0] min_dez,
    output logic [3:0] min_uni,
    output logic [3:0] seg_dez,
    output logic [3:0] seg_uni,
    output logic       zero
);

    tempo_t tempo;
    logic   tick;

    divisor_tick #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_divisor (
        .clk  (clk),
        .rst  (rst),
        .clear(!clrn),
        .en   (ligar),
        .tick (tick)
    );

    // Digit registers: clear, then countdown, then +30 s, then keypad shift-in
    always_ff @(posedge clk) begin
        if (rst) begin
            tempo <= '0;
        end else if (!clrn) begin
            tempo <= '0;
        end else if (tick) begin
            if (!zero) begin
                tempo <= decrementa(tempo);
            end
`ifdef ADD_30S_EN
        end else if (adicionar_30) begin
            tempo <= soma_30(tempo);
`endif
        end else if (tecla_valida && !ligar && (tecla <= TECLA_MAX)) begin
            tempo <= '{min_dez: tempo.min_uni, min_uni: tempo.seg_dez,
                       seg_dez: tempo.seg_uni, seg_uni: tecla};
        end
    end

    assign min_dez = tempo.min_dez;
    assign min_uni = tempo.min_uni;
    assign seg_dez = tempo.seg_dez;
    assign seg_uni = tempo.seg_uni;
    assign zero    = (tempo == '0);

endmodule

// File: tb/tb_temporizador.sv
// tb/tb_temporizador.sv - directed scoreboard bench for temporizador with TICKS_PER_SEC=4
module tb_temporizador;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clrn = 1'b1;
    logic       tecla_valida = 1'b0;
    logic [3:0] tecla = 4'd0;
    logic       ligar = 1'b0;
`ifdef ADD_30S_EN
    logic       adicionar_30 = 1'b0;
`endif
    logic [3:0] min_dez, min_uni, seg_dez, seg_uni;
    logic       zero;

    int checks = 0;
    int erros  = 0;

    typedef struct {
        string       tag;
        logic [15:0] dig;
        logic        z;
    } esperado_t;

    esperado_t fila[$];

    temporizador #(.TICKS_PER_SEC(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .clrn        (clrn),
        .tecla_valida(tecla_valida),
        .tecla       (tecla),
        .ligar       (ligar),
`ifdef ADD_30S_EN
        .adicionar_30(adicionar_30),
`endif
        .min_dez     (min_dez),
        .min_uni     (min_uni),
        .seg_dez     (seg_dez),
        .seg_uni     (seg_uni),
        .zero        (zero)
    );

    always #5 clk = ~clk;

    task automatic ciclo();
        @(posedge clk);
        #1;
    endtask

    task automatic confere();
        esperado_t e;
        logic [15:0] obs;
        e = fila.pop_front();
        obs = {min_dez, min_uni, seg_dez, seg_uni};
        checks++;
        assert (obs === e.dig) else begin
            erros++;
            $error("FAIL %s digits got %h expected %h", e.tag, obs, e.dig);
        end
        checks++;
        assert (zero === e.z) else begin
            erros++;
            $error("FAIL %s zero got %b expected %b", e.tag, zero, e.z);
        end
    endtask

    // Push the expectation, run n cycles with current stimulus, then compare
    task automatic espera(input string tag, input logic [15:0] dig, input logic z, input int n);
        esperado_t e;
        e.tag = tag;
        e.dig = dig;
        e.z   = z;
        fila.push_back(e);
        repeat (n) ciclo();
        confere();
    endtask

    task automatic tecla_em(input logic [3:0] k);
        tecla_valida = 1'b1;
        tecla        = k;
        ciclo();
        tecla_valida = 1'b0;
    endtask

    task automatic limpa();
        clrn = 1'b0;
        ciclo();
        clrn = 1'b1;
    endtask

    initial begin
        ciclo();
        espera("reset", 16'h0000, 1'b1, 1);
        rst = 1'b0;

        tecla_em(4'd1); tecla_em(4'd3); tecla_em(4'd0);
        espera("keys_130", 16'h0130, 1'b0, 0);
        tecla_em(4'd12);
        espera("tecla12_ignored", 16'h0130, 1'b0, 0);
        limpa();
        espera("clrn_idle", 16'h0000, 1'b1, 0);

        tecla_em(4'd0); tecla_em(4'd2);
        espera("keys_002", 16'h0002, 1'b0, 0);
        ligar = 1'b1;
        espera("before_first_tick", 16'h0002, 1'b0, 3);
        espera("first_tick", 16'h0001, 1'b0, 1);
        espera("reach_zero", 16'h0000, 1'b1, 4);
        tecla_em(4'd5);
        espera("key_while_ligar", 16'h0000, 1'b1, 0);
        espera("hold_zero", 16'h0000, 1'b1, 8);
        ligar = 1'b0;
        ciclo();

        tecla_em(4'd1); tecla_em(4'd0); tecla_em(4'd0); tecla_em(4'd0);
        ligar = 1'b1;
        espera("borrow_1000", 16'h0959, 1'b0, 4);
        ligar = 1'b0;
        limpa();
        tecla_em(4'd1); tecla_em(4'd0); tecla_em(4'd0);
        ligar = 1'b1;
        espera("borrow_0100", 16'h0059, 1'b0, 4);

        ligar = 1'b0;
        ciclo();
        ligar = 1'b1;
        ciclo(); ciclo();
        ligar = 1'b0;
        ciclo();
        ligar = 1'b1;
        espera("partial_discarded", 16'h0059, 1'b0, 3);
        espera("retoggle_tick", 16'h0058, 1'b0, 1);
        ligar = 1'b0;
        ciclo();

        limpa();
        tecla_em(4'd5); tecla_em(4'd0); tecla_em(4'd0);
        ligar = 1'b1;
        espera("pre_clrn_tick", 16'h0500, 1'b0, 3);
        clrn = 1'b0;
        espera("clrn_beats_tick", 16'h0000, 1'b1, 1);
        clrn = 1'b1;
        ligar = 1'b0;
        ciclo();

        tecla_em(4'd3); tecla_em(4'd0);
        ligar = 1'b1;
        ciclo(); ciclo();
        rst = 1'b1;
        espera("rst_mid_count", 16'h0000, 1'b1, 1);
        rst = 1'b0;
        ligar = 1'b0;
        ciclo();

        tecla_em(4'd9); tecla_em(4'd9);
        ligar = 1'b1;
        espera("keyed_99", 16'h0098, 1'b0, 4);
        ligar = 1'b0;
        limpa();
        tecla_em(4'd9); tecla_em(4'd0);
        ligar = 1'b1;
        espera("keyed_90", 16'h0089, 1'b0, 4);
        ligar = 1'b0;
        ciclo();

`ifdef ADD_30S_EN
        limpa();
        tecla_em(4'd4); tecla_em(4'd5);
        adicionar_30 = 1'b1;
        espera("add_0045", 16'h0115, 1'b0, 1);
        adicionar_30 = 1'b0;
        limpa();
        tecla_em(4'd9); tecla_em(4'd9); tecla_em(4'd4); tecla_em(4'd0);
        adicionar_30 = 1'b1;
        espera("add_saturate", 16'h9959, 1'b0, 1);
        adicionar_30 = 1'b0;
        limpa();
        tecla_em(4'd1); tecla_em(4'd7); tecla_em(4'd5);
        adicionar_30 = 1'b1;
        espera("add_normalise", 16'h0245, 1'b0, 1);
        adicionar_30 = 1'b0;
        limpa();
        tecla_em(4'd4); tecla_em(4'd5);
        ligar = 1'b1;
        ciclo(); ciclo(); ciclo();
        adicionar_30 = 1'b1;
        espera("add_with_tick", 16'h0044, 1'b0, 1);
        espera("add_while_ligar", 16'h0114, 1'b0, 1);
        adicionar_30 = 1'b0;
        ligar = 1'b0;
        ciclo();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, erros);
        $finish;
    end

endmodule
